// File: rtl/pdes_pkg.sv
// Shared definitions for the event-queue scheduler.
//   - default widths / capacity of the shared prio_q heap
//   - FSM state encoding and heap operation encoding
package pdes_pkg;

  localparam int DWIDTH_DEF     = 32;
  localparam int CWIDTH_DEF     = 5;
  localparam int Q_CAPACITY_DEF = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  typedef enum logic {
    OP_ENQ = 1'b0,
    OP_DEQ = 1'b1
  } op_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   eligible   in   NUM_CORES  per-core eligibility
//   rr_ptr     in   IDX_W      highest-priority core this round
//   winner_oh  out  NUM_CORES  one-hot winner (0 when nothing eligible)
//   winner_idx out  IDX_W      winner index (0 when nothing eligible)
//   any_valid  out  1          at least one core eligible
module rr_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_CORES-1:0] eligible,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [NUM_CORES-1:0] winner_oh,
  output logic [IDX_W-1:0]     winner_idx,
  output logic                 any_valid
);

  // Walk the rotation from farthest to nearest so the core closest to
  // rr_ptr is the last assignment and therefore wins.
  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    any_valid  = 1'b0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_CORES;
      if (eligible[idx]) begin
        winner_oh      = '0;
        winner_oh[idx] = 1'b1;
        winner_idx     = IDX_W'(idx);
        any_valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/event_q_sched.sv
// Event-queue scheduler: arbitrates per-core enqueue/dequeue requests onto
// the single shared prio_q heap, one heap operation per issue slot,
// round-robin between cores, and returns dequeued events to the requester.
//
// Optional feature macro: EVENT_Q_SCHED_OCC_CHECK_EN
//   defined   -> err flags shadow-occupancy / heap-count disagreement (sticky)
//   undefined -> err tied to 0
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_enq/deq   per-core level requests, held until granted
//   req_data      per-core enqueue payload, core i at [i*DWIDTH +: DWIDTH]
//   grant         one-hot, 1-cycle pulse in the issue cycle
//   rsp_valid     one-hot, 1-cycle pulse the cycle after a dequeue issue
//   rsp_data      dequeued event, held between responses
//   q_enq/q_deq   heap operation strobes
//   q_inp_data    heap enqueue payload
//   q_out_data    heap head (minimum timestamp)
//   q_elem_cnt    heap occupancy as reported by prio_q
//   occ           shadow occupancy tracked here
//   err           sticky occupancy-check error
//
// state | meaning
// IDLE  | arbitrate among eligible cores, capture winner/op/payload
// ISSUE | drive heap strobe and grant for one cycle, update occ
// GAP   | hold off further issues for ISSUE_GAP-1 cycles
module event_q_sched
  import pdes_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int DWIDTH     = DWIDTH_DEF,
  parameter int CWIDTH     = CWIDTH_DEF,
  parameter int Q_CAPACITY = Q_CAPACITY_DEF,
  parameter int ISSUE_GAP  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          req_enq,
  input  logic [NUM_CORES-1:0]          req_deq,
  input  logic [NUM_CORES*DWIDTH-1:0]   req_data,
  output logic [NUM_CORES-1:0]          grant,
  output logic [NUM_CORES-1:0]          rsp_valid,
  output logic [DWIDTH-1:0]             rsp_data,
  output logic                          q_enq,
  output logic                          q_deq,
  output logic [DWIDTH-1:0]             q_inp_data,
  input  logic [DWIDTH-1:0]             q_out_data,
  input  logic [CWIDTH-1:0]             q_elem_cnt,
  output logic [CWIDTH-1:0]             occ,
  output logic                          err
);

  localparam int IDX_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int GAP_LOAD = (ISSUE_GAP > 1) ? ISSUE_GAP - 2 : 0;
  localparam int GAP_W    = (GAP_LOAD > 0) ? $clog2(GAP_LOAD + 1) : 1;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       arb_idx, w_idx;
  logic [NUM_CORES-1:0]   elig, arb_oh, w_oh;
  logic                   any_elig;
  op_t                    w_op;
  logic [DWIDTH-1:0]      w_payload;
  logic [GAP_W-1:0]       gap_cnt;
  logic                   not_full, not_empty;

  assign not_full  = (occ < CWIDTH'(Q_CAPACITY));
  assign not_empty = (occ != '0);

  // An enq request masks that core's deq request; the deq stays pending.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      elig[i] = (req_enq[i] && not_full) ||
                (req_deq[i] && !req_enq[i] && not_empty);
    end
  end

  rr_arbiter #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_rr_arbiter (
    .eligible   (elig),
    .rr_ptr     (rr_ptr),
    .winner_oh  (arb_oh),
    .winner_idx (arb_idx),
    .any_valid  (any_elig)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any_elig) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = (ISSUE_GAP > 1) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (gap_cnt == '0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    grant      = '0;
    q_enq      = 1'b0;
    q_deq      = 1'b0;
    q_inp_data = '0;
    if (state == ST_ISSUE) begin
      grant      = w_oh;
      q_enq      = (w_op == OP_ENQ);
      q_deq      = (w_op == OP_DEQ);
      q_inp_data = w_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      occ       <= '0;
      w_idx     <= '0;
      w_oh      <= '0;
      w_op      <= OP_ENQ;
      w_payload <= '0;
      gap_cnt   <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= '0;

      if (state == ST_IDLE && any_elig) begin
        w_idx     <= arb_idx;
        w_oh      <= arb_oh;
        w_op      <= req_enq[arb_idx] ? OP_ENQ : OP_DEQ;
        w_payload <= req_data[arb_idx*DWIDTH +: DWIDTH];
      end

      if (state == ST_ISSUE) begin
        rr_ptr <= (w_idx == IDX_W'(NUM_CORES - 1)) ? '0 : w_idx + 1'b1;
        if (w_op == OP_ENQ) begin
          occ <= occ + 1'b1;
        end else begin
          occ       <= occ - 1'b1;
          rsp_data  <= q_out_data;  // head is the entry being removed
          rsp_valid <= w_oh;
        end
        gap_cnt <= GAP_W'(GAP_LOAD);
      end else if (state == ST_GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

`ifdef EVENT_Q_SCHED_OCC_CHECK_EN
  // Compared only in IDLE, where the heap has settled after the last op.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state == ST_IDLE &&
                 ((occ != q_elem_cnt) || (int'(q_elem_cnt) > Q_CAPACITY))) begin
      err <= 1'b1;
    end
  end
`else
  logic [CWIDTH-1:0] unused_elem_cnt;
  assign unused_elem_cnt = q_elem_cnt;
  assign err             = 1'b0;
`endif

endmodule

// File: tb/tb_event_q_sched.sv
module tb_event_q_sched;
  import pdes_pkg::*;

  localparam int NC = 4;
  localparam int DW = 32;
  localparam int CW = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NC-1:0]     req_enq = '0;
  logic [NC-1:0]     req_deq = '0;
  logic [NC*DW-1:0]  req_data = '0;
  logic [NC-1:0]     grant, rsp_valid;
  logic [DW-1:0]     rsp_data, q_inp_data;
  logic              q_enq, q_deq, err;
  logic [DW-1:0]     q_out_data = '0;
  logic [CW-1:0]     q_elem_cnt, occ;
  logic [CW-1:0]     model_cnt = '0;
  logic              cnt_force_en = 1'b0;
  logic [CW-1:0]     cnt_force_val = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {int core; bit is_enq; logic [DW-1:0] data;} exp_g_t;
  typedef struct {int core; logic [DW-1:0] data;} exp_r_t;
  exp_g_t exp_g[$];
  exp_r_t exp_r[$];

  always #5 clk = ~clk;

  event_q_sched #(.NUM_CORES(NC), .DWIDTH(DW), .CWIDTH(CW),
                  .Q_CAPACITY(31), .ISSUE_GAP(1)) dut (
    .clk(clk), .rst(rst), .req_enq(req_enq), .req_deq(req_deq),
    .req_data(req_data), .grant(grant), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .q_enq(q_enq), .q_deq(q_deq),
    .q_inp_data(q_inp_data), .q_out_data(q_out_data),
    .q_elem_cnt(q_elem_cnt), .occ(occ), .err(err));

  // Reference heap: sorted list, head is the minimum.
  logic [DW-1:0] model_q[$];
  always @(posedge clk) begin
    int pos;
    if (rst) begin
      model_q.delete();
    end else if (q_enq) begin
      pos = 0;
      while (pos < model_q.size() && model_q[pos] <= q_inp_data) pos++;
      model_q.insert(pos, q_inp_data);
    end else if (q_deq && model_q.size() > 0) begin
      void'(model_q.pop_front());
    end
    q_out_data <= (model_q.size() > 0) ? model_q[0] : '0;
    model_cnt  <= CW'(model_q.size());
  end

  assign q_elem_cnt = cnt_force_en ? cnt_force_val : model_cnt;

  // Scoreboard: grants and responses must appear in the pushed order.
  always @(negedge clk) begin
    if (!rst) begin
      if (grant != '0) begin
        checks++;
        if (exp_g.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected: grant=%b required none", grant);
        end else begin
          exp_g_t e;
          logic [NC-1:0] oh;
          e = exp_g.pop_front();
          oh = '0;
          oh[e.core] = 1'b1;
          if (grant !== oh || q_enq !== e.is_enq || q_deq !== !e.is_enq ||
              q_inp_data !== e.data) begin
            errors++;
            $display("FAIL grant_op: grant=%b enq=%b deq=%b data=%0d required grant=%b enq=%b data=%0d",
                     grant, q_enq, q_deq, q_inp_data, oh, e.is_enq, e.data);
          end
        end
      end else if (q_enq || q_deq || q_inp_data != '0) begin
        errors++;
        $display("FAIL idle_strobes: enq=%b deq=%b data=%0d required 0", q_enq, q_deq, q_inp_data);
      end
      if (rsp_valid != '0) begin
        checks++;
        if (exp_r.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: rsp_valid=%b required none", rsp_valid);
        end else begin
          exp_r_t r;
          logic [NC-1:0] oh;
          r = exp_r.pop_front();
          oh = '0;
          oh[r.core] = 1'b1;
          if (rsp_valid !== oh || rsp_data !== r.data) begin
            errors++;
            $display("FAIL rsp: rsp_valid=%b rsp_data=%0d required %b %0d",
                     rsp_valid, rsp_data, oh, r.data);
          end
        end
      end
    end
  end

  task automatic push_g(input int c, input bit is_enq, input logic [DW-1:0] d);
    exp_g_t e;
    e.core = c; e.is_enq = is_enq; e.data = d;
    exp_g.push_back(e);
  endtask

  task automatic push_r(input int c, input logic [DW-1:0] d);
    exp_r_t r;
    r.core = c; r.data = d;
    exp_r.push_back(r);
  endtask

  task automatic set_enq(input int c, input logic [DW-1:0] d);
    req_data[c*DW +: DW] = d;
    req_enq[c] = 1'b1;
    push_g(c, 1'b1, d);
  endtask

  task automatic set_deq(input int c, input logic [DW-1:0] d);
    req_data[c*DW +: DW] = '0;
    req_deq[c] = 1'b1;
    push_g(c, 1'b0, '0);
    push_r(c, d);
  endtask

  task automatic wait_grant(input int c);
    int n = 0;
    @(negedge clk);
    while (!grant[c] && n < 60) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (!grant[c]) begin
      errors++;
      $display("FAIL wait_grant: core %0d grant=%b required bit set within 60 cycles", c, grant);
    end
    req_enq[c] = 1'b0;
    req_deq[c] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_enq = '0;
    req_deq = '0;
    req_data = '0;
    cnt_force_en = 1'b0;
    repeat (2) @(negedge clk);
    exp_g.delete();
    exp_r.delete();
    rst = 1'b0;
  endtask

  task automatic check_drained(input string name);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_g.size() != 0 || exp_r.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: pending grants=%0d rsps=%0d required 0 0",
               name, exp_g.size(), exp_r.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (grant !== '0 || rsp_valid !== '0 || rsp_data !== '0 || q_enq !== 1'b0 ||
        q_deq !== 1'b0 || q_inp_data !== '0 || occ !== '0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b rsp_valid=%b rsp_data=%0d occ=%0d err=%b required all 0",
               grant, rsp_valid, rsp_data, occ, err);
    end
  endtask

  task automatic test_single_core();
    do_reset();
    set_enq(0, 30); wait_grant(0);
    set_enq(0, 10); wait_grant(0);
    set_enq(0, 20); wait_grant(0);
    @(negedge clk);
    checks++;
    if (occ !== 5'd3) begin
      errors++;
      $display("FAIL single_occ_full: occ=%0d required 3", occ);
    end
    set_deq(0, 10); wait_grant(0);
    set_deq(0, 20); wait_grant(0);
    set_deq(0, 30); wait_grant(0);
    @(negedge clk);
    checks++;
    if (occ !== 5'd0) begin
      errors++;
      $display("FAIL single_occ_empty: occ=%0d required 0", occ);
    end
    check_drained("single");
  endtask

  task automatic test_rr_enq();
    do_reset();
    set_enq(0, 4);
    set_enq(1, 3);
    set_enq(2, 2);
    set_enq(3, 1);
    wait_grant(0);
    wait_grant(1);
    wait_grant(2);
    wait_grant(3);
    @(negedge clk);
    checks++;
    if (occ !== 5'd4) begin
      errors++;
      $display("FAIL rr_occ: occ=%0d required 4", occ);
    end
    set_deq(0, 1); wait_grant(0);
    check_drained("rr");
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < 31; k++) begin
      set_enq(0, DW'(100 + k));
      wait_grant(0);
    end
    @(negedge clk);
    checks++;
    if (occ !== 5'd31) begin
      errors++;
      $display("FAIL full_fill_occ: occ=%0d required 31", occ);
    end
    set_enq(1, 5);
    set_deq(2, 100);
    // The blocked enq must not win while the heap is full.
    exp_g.delete();
    push_g(2, 1'b0, '0);
    push_g(1, 1'b1, 5);
    wait_grant(2);
    @(negedge clk);
    checks++;
    if (occ !== 5'd30) begin
      errors++;
      $display("FAIL full_after_deq: occ=%0d required 30", occ);
    end
    wait_grant(1);
    @(negedge clk);
    checks++;
    if (occ !== 5'd31) begin
      errors++;
      $display("FAIL full_after_enq: occ=%0d required 31", occ);
    end
    check_drained("full");
  endtask

  task automatic test_empty_wait();
    int bad = 0;
    do_reset();
    req_deq[3] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (q_deq || grant != '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL empty_wait: %0d cycles with deq/grant required 0", bad);
    end
    req_deq[3] = 1'b0;
    set_enq(0, 7);
    set_deq(3, 7);
    wait_grant(0);
    wait_grant(3);
    check_drained("empty");
    checks++;
    if (occ !== 5'd0) begin
      errors++;
      $display("FAIL empty_final_occ: occ=%0d required 0", occ);
    end
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_enq(0, DW'(50 + k));
      wait_grant(0);
    end
    set_enq(1, 9);
    wait_grant(1);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== '0 || rsp_valid !== '0 || q_enq !== 1'b0 || q_deq !== 1'b0 ||
        q_inp_data !== '0 || occ !== '0 || rsp_data !== '0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs: grant=%b enq=%b occ=%0d rsp_data=%0d required all 0",
               grant, q_enq, occ, rsp_data);
    end
    checks++;
    if (dut.rr_ptr !== 2'd0 || dut.state !== ST_IDLE) begin
      errors++;
      $display("FAIL rst_mid_state: rr_ptr=%0d state=%0d required 0 0", dut.rr_ptr, dut.state);
    end
    exp_g.delete();
    exp_r.delete();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_occ_check();
    logic exp_err;
`ifdef EVENT_Q_SCHED_OCC_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset();
    set_enq(2, 11); wait_grant(2);
    set_enq(2, 12); wait_grant(2);
    repeat (2) @(negedge clk);
    checks++;
    if (occ !== 5'd2 || err !== 1'b0) begin
      errors++;
      $display("FAIL occ_chk_pre: occ=%0d err=%b required 2 0", occ, err);
    end
    cnt_force_val = 5'd3;
    cnt_force_en  = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL occ_chk_set: err=%b required %b", err, exp_err);
    end
    cnt_force_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL occ_chk_sticky: err=%b required %b", err, exp_err);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL occ_chk_clear: err=%b required 0", err);
    end
  endtask

  initial begin
    test_reset();
    test_single_core();
    test_rr_enq();
    test_full();
    test_empty_wait();
    test_reset_mid_issue();
    test_occ_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
